vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, default 200, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 600, active lines per frame.
REQ-003 Parameter ADR_W, default 17, framebuffer address width.
REQ-004 Clocking SHALL be: one clock, CLOCK_50; reset RESET_N, asynchronous, active-low.
REQ-005 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 VGA_CLK  input  1  pixel clock, sampled as data; its rising edge marks a pixel.
REQ-008 VGA_HS  input  1  hsync, active low.
REQ-009 VGA_VS  input  1  vsync, active low.
REQ-010 VGA_BLANK_N  input  1  high = active video.
REQ-011 VGA_R, VGA_G, VGA_B  input  8 each  pixel colour.
REQ-012 cap_en  input  1  arm capture; sampled only at vsync start.
REQ-013 fb_we  output  1  one-cycle framebuffer write strobe.
REQ-014 fb_adr  output  ADR_W  write address.
REQ-015 fb_d  output  24  write data {R,G,B}.
REQ-016 frame_done  output  1  one-cycle pulse when a captured frame ends.
REQ-017 err_geom  output  1  sticky geometry error (see Configuration).

Function
REQ-018 Pixel strobe SHALL be VGA_CLK registered high while its previous registered value was low; HS/VS/BLANK_N/RGB SHALL be registered in the same stage.
REQ-019 HS falling and VS falling SHALL be evaluated only at pixel strobes, against their values at the previous strobe.
REQ-020 FSM states: IDLE, VSYNC, FRAME; reset state IDLE.
REQ-021 IDLE -> VSYNC on VS falling.
REQ-022 VSYNC: x=0, y=0; cap_en at the VS falling strobe sets armed; -> FRAME on VS rising if armed, else stay in IDLE-equivalent wait (-> IDLE).
REQ-023 FRAME: strobe with BLANK_N=1, x<H_ACTIVE, y<V_ACTIVE SHALL write: fb_adr = x + y*H_ACTIVE, fb_d = {R,G,B}, fb_we=1 one cycle later; then x++.
REQ-024 Pixels with x>=H_ACTIVE or y>=V_ACTIVE SHALL be dropped (no write, counters saturate).
REQ-025 FRAME: HS falling with x>0 SHALL set x=0, y++ (y saturates at V_ACTIVE); HS falling with x=0 SHALL change nothing.
REQ-026 FRAME: VS falling SHALL pulse frame_done one cycle, -> VSYNC, re-sample cap_en.
REQ-027 fb_adr/fb_d SHALL hold their last written values between writes; address arithmetic ADR_W wide, no overflow for defaults (max 119999).
REQ-028 HS falling and BLANK_N=1 at the same strobe: write first at current (x,y), then line advance.
REQ-029 Write latency: fb_we asserted exactly 2 CLOCK_50 cycles after VGA_CLK rises at the input pin.

Reset
REQ-030 RESET_N low SHALL immediately force: state IDLE, x=0, y=0, armed=0, fb_we=0, fb_adr=0, fb_d=0, frame_done=0, err_geom=0, sample registers 0 except HS/VS/VGA_CLK registers to 1.
REQ-031 Reset mid-frame SHALL abandon the frame with no frame_done; capture resumes at the next full vsync.

Configuration
REQ-032 Macro VGA_CAPTURE_ERR_EN: defined -> err_geom set when a line ends (HS falling) with 0<x<H_ACTIVE, or a frame ends with y!=V_ACTIVE; sticky until reset.
REQ-033 Not defined -> err_geom tied 0, no check logic synthesised.

Structure
REQ-034 Shared package vga_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the 24-bit pixel typedef, and the FSM state enum.
REQ-035 Sub-module vga_edge_det (registered rise/fall detect) SHALL be instantiated for VGA_CLK, HS, VS.

Verification
REQ-036 Full 200x600 frame of pixel value x+y*200, cap_en=1 -> 120000 writes, fb_adr 0..119999 in order, one frame_done.
REQ-037 cap_en=0 at vsync -> zero writes, no frame_done that frame.
REQ-038 Line with 210 active pixels -> 200 writes, last fb_adr of line 0 = 199; err_geom stays 0.
REQ-039 Line with 150 active pixels, VGA_CAPTURE_ERR_EN defined -> err_geom=1 after that HS falling; undefined -> 0.
REQ-040 RESET_N low at line 300 -> all outputs 0 immediately; next frame after vsync writes from fb_adr 0.
REQ-041 Pixel at x=199 coincident with HS falling -> write at fb_adr y*200+199, next write at (y+1)*200.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame capture block: default frame
// geometry, the packed 24-bit pixel type, the capture FSM states and the
// edge-kind selector used by the edge detector.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 200;
    localparam int V_ACTIVE_DEF = 600;
    localparam int ADR_W_DEF    = 17;

    // One framebuffer word: {R,G,B}
    typedef logic [23:0] pixel_t;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VSYNC = 2'd1,
        FRAME = 2'd2
    } cap_state_t;

    // Which transition an edge detector reports
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1
    } edge_kind_t;

    // Pack three colour channels into one framebuffer word
    function automatic pixel_t pack_rgb(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registered edge detector for a slow signal sampled as data.
// The input is registered every clock; the "previous" register only
// advances when en is high, so with en tied to the pixel strobe the edge
// is judged against the value seen at the previous pixel.
module vga_edge_det
    import vga_pkg::*;
#(
    parameter edge_kind_t EDGE    = EDGE_RISE,
    parameter logic       RST_VAL = 1'b1
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic en,
    input  logic d,
    output logic stb
);

    logic d_reg;
    logic prev_reg;

    // Sample the input each clock; remember the value at the last enable
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            d_reg    <= RST_VAL;
            prev_reg <= RST_VAL;
        end else begin
            d_reg <= d;
            if (en) begin
                prev_reg <= d_reg;
            end
        end
    end

    // Report the selected transition only while enabled
    always_comb begin
        stb = 1'b0;
        if (EDGE == EDGE_RISE) begin
            stb = en & d_reg & ~prev_reg;
        end else begin
            stb = en & ~d_reg & prev_reg;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA frame capture: watches a VGA output bus (pixel clock sampled as data
// on CLOCK_50), and when armed at vsync writes the active area of the next
// frame into a framebuffer, one strobed write per active pixel at address
// x + y*H_ACTIVE. Pixels outside the active window are dropped.
// Optional macro VGA_CAPTURE_ERR_EN enables the sticky geometry checker
// (short line or wrong line count); without it err_geom is tied low.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADR_W    = ADR_W_DEF
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             VGA_CLK,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic             VGA_BLANK_N,
    input  logic [7:0]       VGA_R,
    input  logic [7:0]       VGA_G,
    input  logic [7:0]       VGA_B,
    input  logic             cap_en,
    output logic             fb_we,
    output logic [ADR_W-1:0] fb_adr,
    output pixel_t           fb_d,
    output logic             frame_done,
    output logic             err_geom
);

    // Counters need one value past the active range so they can saturate
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

    // Sampled bus and detected events
    logic   blank_reg;
    pixel_t rgb_reg;
    logic   pix_stb;
    logic   hs_fall;
    logic   vs_fall;
    logic   vs_rise;

    // Controller state
    cap_state_t       state_reg, state_next;
    logic [XW-1:0]    x_reg, x_next;
    logic [YW-1:0]    y_reg, y_next;
    logic             armed_reg, armed_next;
    logic             fb_we_reg, fb_we_next;
    logic [ADR_W-1:0] fb_adr_reg, fb_adr_next;
    pixel_t           fb_d_reg, fb_d_next;
    logic             frame_done_reg, frame_done_next;

    // Per-strobe datapath results
    logic             pix_write;
    logic [ADR_W-1:0] pix_adr;
    logic [XW-1:0]    x_pix;
    logic             line_adv;
    logic [XW-1:0]    x_line;
    logic [YW-1:0]    y_line;

    // Pixel clock: strobe when sampled high after being sampled low
    vga_edge_det #(.EDGE(EDGE_RISE), .RST_VAL(1'b1)) u_clk_det (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .en       (1'b1),
        .d        (VGA_CLK),
        .stb      (pix_stb)
    );

    // Sync edges are judged strobe-to-strobe, not clock-to-clock
    vga_edge_det #(.EDGE(EDGE_FALL), .RST_VAL(1'b1)) u_hs_det (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .en       (pix_stb),
        .d        (VGA_HS),
        .stb      (hs_fall)
    );

    vga_edge_det #(.EDGE(EDGE_FALL), .RST_VAL(1'b1)) u_vs_fall_det (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .en       (pix_stb),
        .d        (VGA_VS),
        .stb      (vs_fall)
    );

    vga_edge_det #(.EDGE(EDGE_RISE), .RST_VAL(1'b1)) u_vs_rise_det (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .en       (pix_stb),
        .d        (VGA_VS),
        .stb      (vs_rise)
    );

    // Register blank and colour in the same stage as the sync/clock samples
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blank_reg <= 1'b0;
            rgb_reg   <= '0;
        end else begin
            blank_reg <= VGA_BLANK_N;
            rgb_reg   <= pack_rgb(VGA_R, VGA_G, VGA_B);
        end
    end

    // Pixel write decision, then line advance applied to the post-write x
    always_comb begin
        pix_write = pix_stb && blank_reg && (x_reg < X_MAX) && (y_reg < Y_MAX);
        pix_adr   = ADR_W'(x_reg) + ADR_W'(y_reg) * ADR_W'(H_ACTIVE);
        x_pix     = x_reg;
        if (pix_stb && blank_reg && (x_reg < X_MAX)) begin
            x_pix = x_reg + XW'(1);
        end
        line_adv = hs_fall && (x_pix != '0);
        x_line   = line_adv ? '0 : x_pix;
        y_line   = y_reg;
        if (line_adv && (y_reg < Y_MAX)) begin
            y_line = y_reg + YW'(1);
        end
    end

    // Controller next-state and output logic
    always_comb begin
        state_next      = state_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        armed_next      = armed_reg;
        fb_we_next      = 1'b0;
        fb_adr_next     = fb_adr_reg;
        fb_d_next       = fb_d_reg;
        frame_done_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (vs_fall) begin
                    state_next = VSYNC;
                    armed_next = cap_en;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            VSYNC: begin
                x_next = '0;
                y_next = '0;
                if (vs_rise) begin
                    state_next = armed_reg ? FRAME : IDLE;
                end
            end
            FRAME: begin
                if (pix_write) begin
                    fb_we_next  = 1'b1;
                    fb_adr_next = pix_adr;
                    fb_d_next   = rgb_reg;
                end
                if (pix_stb) begin
                    x_next = x_line;
                    y_next = y_line;
                end
                if (vs_fall) begin
                    frame_done_next = 1'b1;
                    state_next      = VSYNC;
                    armed_next      = cap_en;
                    x_next          = '0;
                    y_next          = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller state and output registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            armed_reg      <= 1'b0;
            fb_we_reg      <= 1'b0;
            fb_adr_reg     <= '0;
            fb_d_reg       <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            armed_reg      <= armed_next;
            fb_we_reg      <= fb_we_next;
            fb_adr_reg     <= fb_adr_next;
            fb_d_reg       <= fb_d_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign fb_we      = fb_we_reg;
    assign fb_adr     = fb_adr_reg;
    assign fb_d       = fb_d_reg;
    assign frame_done = frame_done_reg;

`ifdef VGA_CAPTURE_ERR_EN
    logic err_reg;

    // Sticky: a non-empty line shorter than H_ACTIVE, or a frame whose
    // line count is not exactly V_ACTIVE
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            err_reg <= 1'b0;
        end else if (state_reg == FRAME) begin
            if ((line_adv && (x_pix < X_MAX)) || (vs_fall && (y_line != Y_MAX))) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_geom = err_reg;
`else
    assign err_geom = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture. Frames are described line by line
// (number of active pixels per line); the expected framebuffer writes are
// derived from that description and queued as pixels are driven, and a
// monitor pops and compares each write / frame_done against the queues.
module tb_vga_capture;
    import vga_pkg::*;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 17;
`ifdef VGA_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N = 1'b0;
    logic          VGA_CLK = 1'b0;
    logic          VGA_HS = 1'b1;
    logic          VGA_VS = 1'b1;
    logic          VGA_BLANK_N = 1'b0;
    logic [7:0]    VGA_R = '0;
    logic [7:0]    VGA_G = '0;
    logic [7:0]    VGA_B = '0;
    logic          cap_en = 1'b0;
    logic          fb_we;
    logic [AW-1:0] fb_adr;
    logic [23:0]   fb_d;
    logic          frame_done;
    logic          err_geom;

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADR_W(AW)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .cap_en      (cap_en),
        .fb_we       (fb_we),
        .fb_adr      (fb_adr),
        .fb_d        (fb_d),
        .frame_done  (frame_done),
        .err_geom    (err_geom)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int unsigned cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] adr;
        logic [23:0]   d;
        int unsigned   at;
    } wr_t;

    wr_t           wq[$];
    int unsigned   fdq[$];
    int            tests = 0;
    int            fails = 0;
    bit            armed_frame = 1'b0;
    int            line_y = 0;
    bit            exp_err = 1'b0;
    bit            use_pattern = 1'b0;
    logic [AW-1:0] last_adr = '0;
    logic [23:0]   last_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write and frame_done is matched against the queues
    initial begin
        wr_t e;
        int unsigned t;
        forever begin
            @(negedge CLOCK_50);
            if (RESET_N) begin
                if (fb_we) begin
                    if (wq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got write adr=%0d data=%0h, required none", fb_adr, fb_d);
                    end else begin
                        e = wq.pop_front();
                        check("wr_adr", 32'(fb_adr), 32'(e.adr));
                        check("wr_data", 32'(fb_d), 32'(e.d));
                        check("wr_latency", cyc, e.at);
                    end
                end else if (wq.size() != 0 && wq[0].at < cyc) begin
                    e = wq.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missing_write: got none by cycle %0d, required adr=%0d at cycle %0d", cyc, e.adr, e.at);
                end
                if (frame_done) begin
                    if (fdq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame_done: got pulse at cycle %0d, required none", cyc);
                    end else begin
                        t = fdq.pop_front();
                        check("frame_done_cycle", cyc, t);
                    end
                end else if (fdq.size() != 0 && fdq[0] < cyc) begin
                    t = fdq.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missing_frame_done: got none by cycle %0d, required at cycle %0d", cyc, t);
                end
            end
        end
    end

    // One pixel-clock period; queue the expected write / frame_done
    task automatic pix(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb,
                       input bit exp_wr, input logic [AW-1:0] adr, input bit exp_fd);
        @(negedge CLOCK_50);
        VGA_CLK = 1'b0;
        VGA_HS = hs;
        VGA_VS = vs;
        VGA_BLANK_N = blank;
        {VGA_R, VGA_G, VGA_B} = rgb;
        repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        VGA_CLK = 1'b1;
        if (exp_wr) begin
            wq.push_back('{adr, rgb, cyc + 2});
            last_adr = adr;
            last_d = rgb;
        end
        if (exp_fd) fdq.push_back(cyc + 2);
        repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
    endtask

    // A line of n active pixels followed by hsync; line index = count of
    // earlier non-empty lines, clamped at V
    task automatic drive_line(input int n, input bit coincide);
        int y;
        bit wr;
        logic [AW-1:0] adr;
        logic [23:0] dat;
        y = (line_y < V) ? line_y : V;
        cap_en = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            wr = armed_frame && (i < H) && (y < V);
            adr = AW'(i + y * H);
            dat = use_pattern ? 24'(adr) : 24'($urandom);
            pix(!(coincide && (i == n - 1)), 1'b1, 1'b1, dat, wr, adr, 1'b0);
        end
        if (!(coincide && n > 0)) pix(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0, '0, 1'b0);
        pix(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0, '0, 1'b0);
        pix(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0, '0, 1'b0);
        if (n > 0) begin
            if (ERR_EN && armed_frame && n < H) exp_err = 1'b1;
            line_y++;
        end
    endtask

    // Vertical sync: ends the current frame and arms (or not) the next
    task automatic drive_vsync(input bit cap);
        bit fd;
        int y;
        fd = armed_frame;
        y = (line_y < V) ? line_y : V;
        if (ERR_EN && armed_frame && y != V) exp_err = 1'b1;
        cap_en = cap;
        pix(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0, '0, fd);
        pix(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0, '0, 1'b0);
        pix(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0, '0, 1'b0);
        pix(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0, '0, 1'b0);
        armed_frame = cap;
        line_y = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (wq.size() == 0 && fdq.size() == 0) break;
            @(negedge CLOCK_50);
        end
        repeat (3) @(negedge CLOCK_50);
        check("queue_empty", 32'(wq.size() + fdq.size()), 32'd0);
    endtask

    task automatic end_checks();
        drain();
        check("err_geom", 32'(err_geom), 32'(exp_err));
        check("fb_adr_hold", 32'(fb_adr), 32'(last_adr));
        check("fb_d_hold", 32'(fb_d), 32'(last_d));
    endtask

    task automatic reset_checks();
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_adr", 32'(fb_adr), 32'd0);
        check("rst_fb_d", 32'(fb_d), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_geom", 32'(err_geom), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_checks();
        RESET_N = 1'b1;
        repeat (4) pix(1'b1, 1'b1, 1'b0, 24'd0, 1'b0, '0, 1'b0);

        // Full frame with pixel value = address, plus one line past the bottom
        drive_vsync(1'b1);
        use_pattern = 1'b1;
        for (int l = 0; l <= V; l++) drive_line(H, 1'b0);
        use_pattern = 1'b0;
        drive_vsync(1'b0);
        end_checks();

        // Not armed: no writes, no frame_done for this frame
        for (int l = 0; l < V; l++) drive_line(int'($urandom_range(0, H + 3)), 1'b0);
        drive_vsync(1'b1);
        end_checks();

        // Geometry corners: long line, HS on last pixel, empty line, short line
        drive_line(H + 5, 1'b0);
        drive_line(H, 1'b1);
        drive_line(0, 1'b0);
        drive_line(H / 2, 1'b0);
        for (int l = 4; l < V; l++) drive_line(H + int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        drive_vsync(1'b1);
        end_checks();

        // Reset in the middle of a captured frame
        drive_line(H, 1'b0);
        drive_line(H, 1'b1);
        drive_line(H, 1'b0);
        drain();
        check("pre_reset_fb_adr", 32'(fb_adr), 32'(last_adr));
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        reset_checks();
        armed_frame = 1'b0;
        exp_err = 1'b0;
        last_adr = '0;
        last_d = '0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        drive_line(H, 1'b0);
        drive_line(H, 1'b0);
        drive_vsync(1'b1);
        end_checks();

        // Capture resumes from address 0
        for (int l = 0; l < V; l++) drive_line(H, 1'($urandom_range(0, 1)));
        drive_vsync(1'b0);
        end_checks();
        drive_line(H, 1'b0);
        drive_vsync(1'b0);
        end_checks();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
